// File: rtl/mux7_rr_scheduler.sv
// mux7_rr_scheduler
//   Round-robin owner of a shared 7:1 single-bit mux. A registered one-hot
//   grant drives the mux select. No requester keeps the grant for more than
//   MAX_HOLD consecutive cycles while others are waiting. The mux output is
//   registered into a sample stream that is tagged with its source and
//   qualified by a valid bit.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   req[6:0]   in   bit k requests mux input ik
//   mux_y      in   output y of the shared mux
//   select     out  mux select, registered, 0..6; holds while idle
//   grant      out  one-hot grant, registered; zero when idle
//   busy       out  high while a grant is active (FSM is in GRANT)
//   data_out   out  registered sample of mux_y
//   data_src   out  select value in effect when data_out was sampled
//   data_valid out  data_out/data_src valid this cycle
//
// Handshake: req is level-sensitive and is only looked at on clock edges.
// A requester may consider itself served in any cycle where its grant bit
// is high. The matching sample appears one cycle later with data_valid=1.
module mux7_rr_scheduler #(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] req,
    input  logic       mux_y,
    output logic [2:0] select,
    output logic [6:0] grant,
    output logic       busy,
    output logic       data_out,
    output logic [2:0] data_src,
    output logic       data_valid
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [HOLD_W-1:0] MAX_HOLD_V = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

    state_t            state, state_nx;
    logic [2:0]        ptr, ptr_nx;
    logic [2:0]        select_nx;
    logic [6:0]        grant_nx;
    logic [HOLD_W-1:0] hold, hold_nx;

    logic              found;
    logic [2:0]        win;
    logic [3:0]        sum;
    logic [2:0]        idx;

    // Round-robin search. The scan starts just after ptr and looks at ptr
    // itself last. While a grant is active, ptr equals select, so the same
    // scan serves both the idle search and the leave search from cur+1.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        sum   = 4'd0;
        idx   = 3'd0;
        for (int k = 1; k <= 7; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            idx = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        select_nx = select;
        hold_nx   = hold;
        ptr_nx    = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx  = GRANT;
                    grant_nx  = 7'b1 << win;
                    select_nx = win;
                    hold_nx   = HOLD_ONE;
                    ptr_nx    = win;
                end
            end
            GRANT: begin
                if (req[select] && (hold < MAX_HOLD_V)) begin
                    hold_nx = hold + HOLD_ONE;
                end else if (found) begin
                    // Switch directly with no idle bubble. If only the
                    // current owner is still requesting, the scan returns it
                    // and it is re-granted with a fresh hold count.
                    state_nx  = GRANT;
                    grant_nx  = 7'b1 << win;
                    select_nx = win;
                    hold_nx   = HOLD_ONE;
                    ptr_nx    = win;
                end else begin
                    state_nx = IDLE;
                    grant_nx = 7'b0;
                    hold_nx  = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = 7'b0;
                hold_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= 7'b0;
            select <= 3'd0;
            hold   <= '0;
            ptr    <= 3'd6;
        end else begin
            state  <= state_nx;
            grant  <= grant_nx;
            select <= select_nx;
            hold   <= hold_nx;
            ptr    <= ptr_nx;
        end
    end

    // Sample the mux during every granted cycle. This includes the last one,
    // even when its request has already dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= 1'b0;
            data_src   <= 3'd0;
            data_valid <= 1'b0;
        end else if (state == GRANT) begin
            data_out   <= mux_y;
            data_src   <= select;
            data_valid <= 1'b1;
        end else begin
            data_valid <= 1'b0;
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: doc/mux7_rr_scheduler.md
Name: mux7_rr_scheduler

Overview:
Round-robin scheduler that shares one 7:1 single-bit mux (inputs i0..i6, 3-bit select, output y) among seven requesters. It drives the mux select from a registered one-hot grant and bounds each grant to MAX_HOLD cycles. It registers the mux output into a tagged, valid-qualified sample stream. It sits directly in front of the mux and owns its select line.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant (legal range 1..7)
HOLD_W, 3, width of the internal hold counter (must hold MAX_HOLD)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req  input  7  request per mux input; bit k requests input ik
mux_y  input  1  output y of the shared 7:1 mux
select  output  3  mux select, registered, range 0..6
grant  output  7  one-hot grant, registered; all zero when idle
busy  output  1  high while in GRANT
data_out  output  1  registered sample of mux_y
data_src  output  3  select value in effect when data_out was sampled
data_valid  output  1  data_out/data_src valid this cycle

Behaviour:
- Reset: async, active-high, applied the same way whether idle or mid-grant.
  - state=IDLE, grant=0, select=0, busy=0.
  - data_out=0, data_src=0, data_valid=0.
  - hold counter=0; last-grant pointer=6, so the first search starts at index 0.
- States:
  - IDLE: grant=0, busy=0; select keeps its last value.
  - GRANT: exactly one grant bit set, select=its index, busy=1.
- Round-robin search: scan indices ptr+1, ptr+2, ... mod 7 over all 7 positions, ptr itself last; the first asserted req wins.
- IDLE -> GRANT:
  - Condition: at a clock edge where req != 0.
  - Effect: grant/select = search winner (ptr = last grant), hold=1, ptr = winner.
  - Latency: grant is visible 1 cycle after req is sampled.
- GRANT, at each edge, with cur = select:
  - Stay: req[cur]=1 and hold < MAX_HOLD -> keep grant, hold++.
  - Leave: otherwise, search from cur+1.
    - Winner found: switch grant directly to it, hold=1, ptr=winner; no idle bubble.
    - Only cur still requesting after hold expiry: cur is re-granted, hold=1.
    - No requester: go to IDLE, grant=0.
- Sampling:
  - At every edge where state=GRANT: data_out <= mux_y, data_src <= select, data_valid <= 1.
  - At every other edge: data_valid <= 0; data_out and data_src hold.
  - data_valid therefore lags grant by exactly 1 cycle.
  - The last granted cycle is sampled even if its req dropped.
- Simultaneous events: req changes are acted on only at edges. A requester that deasserts in the same cycle its hold expires is treated as a release.
- Invariants:
  - select is never 7.
  - grant is all zero or exactly one-hot.
  - grant is never given to a requester whose req was 0 at the deciding edge.
- MAX_HOLD=1: the grant rotates every cycle whenever more than one requester is active.

Test Plan:
1. Reset: assert rst mid-simulation with req=7'h7F -> grant=0, select=0, busy=0, data_valid=0 asynchronously. Release rst -> first grant=7'b0000001.
2. Single requester: req=7'b0000100 for 3 cycles, mux_y=1 -> grant=7'b0000100, select=2 from cycle+1. data_valid=1, data_out=1, data_src=2 on cycles +2..+4. Then IDLE, grant=0, select stays 2.
3. Full contention: MAX_HOLD=4, req=7'h7F constant -> select sequence 0,1,2,3,4,5,6,0, each held 4 cycles, busy continuously 1, no gaps.
4. Wrap-around: with ptr=5 and req=7'b1000001 -> grant order 6 then 0.
5. Early release and re-grant: req=7'b0001000 only, dropped after 2 cycles -> IDLE after 2 grant cycles. Held 10 cycles with MAX_HOLD=4 -> re-granted at index 3 every 4 cycles, hold restarts.
6. Reset mid-grant: rst pulse while grant=7'b0010000, data_valid=1 -> all outputs clear immediately. After release with req=7'b0010000 -> grant returns after 1 cycle with search restarting from 0.
